dummy_accelerator_issuer: RTL and testbench



---
 rtl/dummy_accelerator_issuer.sv | 173 +++++++++++++++++
 tb/tb_dummy_accelerator_issuer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dummy_accelerator_issuer.sv
// Requester side of the dummy accelerator valid/ready/imm protocol.
// Takes one upstream command, pulses it to the accelerator for one cycle,
// buffers the result and returns it upstream with the measured latency.
// A watchdog flushes the accelerator if no result arrives in time.
module dummy_accelerator_issuer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned IMM_WIDTH      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned LAT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [IMM_WIDTH-1:0]  cmd_imm_i,
  input  logic [DATA_WIDTH-1:0] cmd_op_a_i,
  input  logic [DATA_WIDTH-1:0] cmd_op_b_i,
  output logic                  acc_valid_o,
  output logic [IMM_WIDTH-1:0]  acc_imm_o,
  output logic [DATA_WIDTH-1:0] acc_op_a_o,
  output logic [DATA_WIDTH-1:0] acc_op_b_o,
  output logic                  acc_flush_o,
  input  logic                  acc_res_valid_i,
  input  logic [DATA_WIDTH-1:0] acc_res_i,
  output logic                  acc_ready_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic                  res_err_o,
  output logic [LAT_W-1:0]      res_lat_o
);

  localparam logic [LAT_W-1:0] TimeoutVal = LAT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitRes,
    StAbort,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [IMM_WIDTH-1:0]  imm_q, imm_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [LAT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [LAT_W-1:0]      lat_q, lat_d;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      imm_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state, command capture, latency counting and result buffering.
  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    lat_d   = lat_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          imm_d   = cmd_imm_i;
          op_a_d  = cmd_op_a_i;
          op_b_d  = cmd_op_b_i;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Counter is 0 here, so the first wait cycle sees 1.
        cnt_d = cnt_q + 1'b1;
        if (acc_res_valid_i) begin
          data_d  = acc_res_i;
          lat_d   = '0;
          state_d = StResp;
        end else begin
          state_d = StWaitRes;
        end
      end
      StWaitRes: begin
        if (cnt_q != TimeoutVal) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A result wins over the timeout in the same cycle.
        if (acc_res_valid_i) begin
          data_d  = acc_res_i;
          lat_d   = cnt_q;
          state_d = StResp;
        end else if (cnt_q == TimeoutVal) begin
          state_d = StAbort;
        end
      end
      StAbort: begin
        err_d   = 1'b1;
        data_d  = '0;
        lat_d   = TimeoutVal;
        state_d = StResp;
      end
      StResp: begin
        if (res_ready_i) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Flush overrides every transition, including a same-cycle result capture.
    if (flush_i) begin
      state_d = StIdle;
      err_d   = 1'b0;
      data_d  = data_q;
      lat_d   = lat_q;
    end
  end

  // Outputs decoded from state and registers; only the flush sees an input.
  always_comb begin
    cmd_ready_o = 1'b0;
    acc_valid_o = 1'b0;
    acc_ready_o = 1'b0;
    res_valid_o = 1'b0;
    case (state_q)
      StIdle:    cmd_ready_o = 1'b1;
      StIssue: begin
        acc_valid_o = 1'b1;
        acc_ready_o = 1'b1;
      end
      StWaitRes: acc_ready_o = 1'b1;
      StResp:    res_valid_o = 1'b1;
      default:   ;
    endcase
    acc_flush_o = flush_i | (state_q == StAbort);
  end

  assign acc_imm_o  = imm_q;
  assign acc_op_a_o = op_a_q;
  assign acc_op_b_o = op_b_q;
  assign res_data_o = data_q;
  assign res_err_o  = err_q;
  assign res_lat_o  = lat_q;

endmodule

// File: tb/tb_dummy_accelerator_issuer.sv
// Directed bench for dummy_accelerator_issuer with an 8-cycle watchdog.
module tb_dummy_accelerator_issuer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_imm;
  logic [31:0] cmd_op_a;
  logic [31:0] cmd_op_b;
  logic        acc_valid;
  logic [2:0]  acc_imm;
  logic [31:0] acc_op_a;
  logic [31:0] acc_op_b;
  logic        acc_flush;
  logic        acc_res_valid;
  logic [31:0] acc_res;
  logic        acc_ready;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic [3:0]  res_lat;

  int vectors;
  int miscompares;
  int acc_pulses;

  dummy_accelerator_issuer #(
    .DATA_WIDTH     (32),
    .IMM_WIDTH      (3),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .cmd_imm_i       (cmd_imm),
    .cmd_op_a_i      (cmd_op_a),
    .cmd_op_b_i      (cmd_op_b),
    .acc_valid_o     (acc_valid),
    .acc_imm_o       (acc_imm),
    .acc_op_a_o      (acc_op_a),
    .acc_op_b_o      (acc_op_b),
    .acc_flush_o     (acc_flush),
    .acc_res_valid_i (acc_res_valid),
    .acc_res_i       (acc_res),
    .acc_ready_o     (acc_ready),
    .res_valid_o     (res_valid),
    .res_ready_i     (res_ready),
    .res_data_o      (res_data),
    .res_err_o       (res_err),
    .res_lat_o       (res_lat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count request pulses away from the active edge.
  always @(negedge clk) begin
    if (acc_valid === 1'b1) acc_pulses <= acc_pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From an IDLE cycle: present a command, return in the ISSUE cycle.
  task automatic send_cmd(input logic [2:0] imm, input logic [31:0] a, input logic [31:0] b);
    cmd_valid = 1'b1;
    cmd_imm   = imm;
    cmd_op_a  = a;
    cmd_op_b  = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    vectors++; if (acc_valid !== 1'b0) begin miscompares++; $display("FAIL rst_acc_valid: got %b want 0", acc_valid); end
    vectors++; if (acc_ready !== 1'b0) begin miscompares++; $display("FAIL rst_acc_ready: got %b want 0", acc_ready); end
    vectors++; if (acc_flush !== 1'b0) begin miscompares++; $display("FAIL rst_acc_flush: got %b want 0", acc_flush); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    vectors++; if (res_err !== 1'b0) begin miscompares++; $display("FAIL rst_res_err: got %b want 0", res_err); end
    vectors++; if (res_data !== 32'h0) begin miscompares++; $display("FAIL rst_res_data: got %h want 0", res_data); end
    vectors++; if (res_lat !== 4'd0) begin miscompares++; $display("FAIL rst_res_lat: got %0d want 0", res_lat); end
    vectors++; if (acc_op_a !== 32'h0 || acc_imm !== 3'd0) begin miscompares++; $display("FAIL rst_acc_regs: got %h/%0d want 0/0", acc_op_a, acc_imm); end
    #11;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_comb();
    res_ready = 1'b1;
    send_cmd(3'd0, 32'h11, 32'h22);
    acc_res_valid = 1'b1;
    acc_res       = 32'h1234;
    #2;
    vectors++; if (acc_valid !== 1'b1 || acc_ready !== 1'b1) begin miscompares++; $display("FAIL comb_issue: got valid=%b ready=%b want 1/1", acc_valid, acc_ready); end
    vectors++; if (acc_op_a !== 32'h11 || acc_op_b !== 32'h22 || acc_imm !== 3'd0) begin miscompares++; $display("FAIL comb_ops: got %h %h %0d want 11 22 0", acc_op_a, acc_op_b, acc_imm); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL comb_issue_cmd_ready: got %b want 0", cmd_ready); end
    tick();
    acc_res_valid = 1'b0;
    #2;
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL comb_res_valid: got %b want 1", res_valid); end
    vectors++; if (res_data !== 32'h1234) begin miscompares++; $display("FAIL comb_data: got %h want 00001234", res_data); end
    vectors++; if (res_lat !== 4'd0 || res_err !== 1'b0) begin miscompares++; $display("FAIL comb_lat_err: got %0d/%b want 0/0", res_lat, res_err); end
    vectors++; if (acc_valid !== 1'b0 || cmd_ready !== 1'b0) begin miscompares++; $display("FAIL comb_resp_ctl: got av=%b cr=%b want 0/0", acc_valid, cmd_ready); end
    tick();
    res_ready = 1'b0;
    #2;
    vectors++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL comb_idle: got cr=%b rv=%b want 1/0", cmd_ready, res_valid); end
  endtask

  task automatic test_latency3();
    int p0;
    p0 = acc_pulses;
    send_cmd(3'd3, 32'hCA, 32'hFE);
    #2;
    vectors++; if (acc_valid !== 1'b1 || acc_imm !== 3'd3) begin miscompares++; $display("FAIL lat3_issue: got %b/%0d want 1/3", acc_valid, acc_imm); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) begin
        acc_res_valid = 1'b1;
        acc_res       = 32'hCAFEF00D;
      end
      #2;
      vectors++; if (acc_ready !== 1'b1 || acc_valid !== 1'b0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL lat3_wait%0d: got ar=%b av=%b rv=%b want 1/0/0", k, acc_ready, acc_valid, res_valid); end
    end
    tick();
    acc_res_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) res_ready = 1'b1;
      #2;
      vectors++; if (res_valid !== 1'b1 || res_data !== 32'hCAFEF00D || res_lat !== 4'd3) begin miscompares++; $display("FAIL lat3_hold%0d: got rv=%b %h lat=%0d want 1 cafef00d 3", k, res_valid, res_data, res_lat); end
      vectors++; if (cmd_ready !== 1'b0 || acc_valid !== 1'b0) begin miscompares++; $display("FAIL lat3_hold_ctl%0d: got cr=%b av=%b want 0/0", k, cmd_ready, acc_valid); end
      tick();
    end
    res_ready = 1'b0;
    #2;
    vectors++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL lat3_idle: got cr=%b rv=%b want 1/0", cmd_ready, res_valid); end
    vectors++; if (acc_pulses - p0 !== 1) begin miscompares++; $display("FAIL lat3_pulses: got %0d want 1", acc_pulses - p0); end
  endtask

  task automatic test_timeout();
    send_cmd(3'd7, 32'h1, 32'h2);
    #2;
    vectors++; if (acc_flush !== 1'b0) begin miscompares++; $display("FAIL to_issue_flush: got %b want 0", acc_flush); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      #2;
      vectors++; if (acc_flush !== 1'b0 || acc_ready !== 1'b1) begin miscompares++; $display("FAIL to_wait%0d: got fl=%b ar=%b want 0/1", k, acc_flush, acc_ready); end
    end
    tick();
    #2;
    vectors++; if (acc_flush !== 1'b1 || acc_ready !== 1'b0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL to_abort: got fl=%b ar=%b rv=%b want 1/0/0", acc_flush, acc_ready, res_valid); end
    tick();
    #2;
    vectors++; if (acc_flush !== 1'b0) begin miscompares++; $display("FAIL to_flush_len: got %b want 0", acc_flush); end
    vectors++; if (res_valid !== 1'b1 || res_err !== 1'b1) begin miscompares++; $display("FAIL to_resp: got rv=%b err=%b want 1/1", res_valid, res_err); end
    vectors++; if (res_data !== 32'h0 || res_lat !== 4'd8) begin miscompares++; $display("FAIL to_data_lat: got %h/%0d want 0/8", res_data, res_lat); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #2;
    vectors++; if (res_err !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL to_idle: got err=%b rv=%b cr=%b want 0/0/1", res_err, res_valid, cmd_ready); end
  endtask

  task automatic test_edge_result();
    send_cmd(3'd5, 32'h5, 32'h6);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 8) begin
        acc_res_valid = 1'b1;
        acc_res       = 32'hA5A50008;
      end
      #2;
      vectors++; if (acc_flush !== 1'b0) begin miscompares++; $display("FAIL edge_wait%0d_flush: got %b want 0", k, acc_flush); end
    end
    tick();
    acc_res_valid = 1'b0;
    #2;
    vectors++; if (res_valid !== 1'b1 || res_err !== 1'b0 || acc_flush !== 1'b0) begin miscompares++; $display("FAIL edge_resp: got rv=%b err=%b fl=%b want 1/0/0", res_valid, res_err, acc_flush); end
    vectors++; if (res_data !== 32'hA5A50008 || res_lat !== 4'd8) begin miscompares++; $display("FAIL edge_data_lat: got %h/%0d want a5a50008/8", res_data, res_lat); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #2;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL edge_idle: got %b want 1", cmd_ready); end
  endtask

  task automatic test_flush();
    send_cmd(3'd2, 32'h7, 32'h8);
    tick();
    flush         = 1'b1;
    acc_res_valid = 1'b1;
    acc_res       = 32'hBADBAD00;
    #2;
    vectors++; if (acc_flush !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL flush_cycle: got fl=%b rv=%b want 1/0", acc_flush, res_valid); end
    tick();
    flush         = 1'b0;
    acc_res_valid = 1'b0;
    #2;
    vectors++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || acc_flush !== 1'b0 || acc_ready !== 1'b0) begin miscompares++; $display("FAIL flush_idle: got cr=%b rv=%b fl=%b ar=%b want 1/0/0/0", cmd_ready, res_valid, acc_flush, acc_ready); end
    vectors++; if (res_data !== 32'hA5A50008) begin miscompares++; $display("FAIL flush_no_capture: got %h want a5a50008", res_data); end
    tick();
    #2;
    vectors++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL flush_settled: got rv=%b cr=%b want 0/1", res_valid, cmd_ready); end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = acc_pulses;
    acc_res_valid = 1'b1;
    acc_res       = 32'hDEAD0000;
    #2;
    vectors++; if (acc_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_stray_ready: got %b want 0", acc_ready); end
    tick();
    acc_res_valid = 1'b0;
    #2;
    vectors++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'hA5A50008) begin miscompares++; $display("FAIL b2b_idle_stray: got cr=%b rv=%b %h want 1/0 a5a50008", cmd_ready, res_valid, res_data); end
    cmd_valid = 1'b1;
    cmd_imm   = 3'd1;
    cmd_op_a  = 32'd100;
    cmd_op_b  = 32'd200;
    tick();
    // Second command waits on the bus while the first is in flight.
    cmd_imm  = 3'd0;
    cmd_op_a = 32'd300;
    cmd_op_b = 32'd400;
    #2;
    vectors++; if (acc_valid !== 1'b1 || acc_op_a !== 32'd100 || acc_op_b !== 32'd200 || acc_imm !== 3'd1) begin miscompares++; $display("FAIL b2b_issue1: got av=%b %0d %0d %0d want 1 100 200 1", acc_valid, acc_op_a, acc_op_b, acc_imm); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_issue1_cr: got %b want 0", cmd_ready); end
    tick();
    acc_res_valid = 1'b1;
    acc_res       = 32'h00000101;
    #2;
    vectors++; if (acc_valid !== 1'b0 || acc_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_wait1: got av=%b ar=%b want 0/1", acc_valid, acc_ready); end
    tick();
    acc_res       = 32'h0000BEEF;
    #2;
    vectors++; if (res_valid !== 1'b1 || res_data !== 32'h101 || res_lat !== 4'd1) begin miscompares++; $display("FAIL b2b_resp1: got rv=%b %h lat=%0d want 1 00000101 1", res_valid, res_data, res_lat); end
    vectors++; if (acc_ready !== 1'b0 || cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_resp1_ctl: got ar=%b cr=%b want 0/0", acc_ready, cmd_ready); end
    tick();
    acc_res_valid = 1'b0;
    res_ready     = 1'b1;
    #2;
    vectors++; if (res_valid !== 1'b1 || res_data !== 32'h101 || res_lat !== 4'd1) begin miscompares++; $display("FAIL b2b_resp_stray: got rv=%b %h lat=%0d want 1 00000101 1", res_valid, res_data, res_lat); end
    tick();
    #2;
    vectors++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle2: got cr=%b rv=%b want 1/0", cmd_ready, res_valid); end
    tick();
    cmd_valid     = 1'b0;
    acc_res_valid = 1'b1;
    acc_res       = 32'h00000202;
    #2;
    vectors++; if (acc_valid !== 1'b1 || acc_op_a !== 32'd300 || acc_op_b !== 32'd400 || acc_imm !== 3'd0) begin miscompares++; $display("FAIL b2b_issue2: got av=%b %0d %0d %0d want 1 300 400 0", acc_valid, acc_op_a, acc_op_b, acc_imm); end
    tick();
    acc_res_valid = 1'b0;
    #2;
    vectors++; if (res_valid !== 1'b1 || res_data !== 32'h202 || res_lat !== 4'd0) begin miscompares++; $display("FAIL b2b_resp2: got rv=%b %h lat=%0d want 1 00000202 0", res_valid, res_data, res_lat); end
    tick();
    res_ready = 1'b0;
    #2;
    vectors++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle3: got cr=%b rv=%b want 1/0", cmd_ready, res_valid); end
    vectors++; if (acc_pulses - p0 !== 2) begin miscompares++; $display("FAIL b2b_pulses: got %0d want 2", acc_pulses - p0); end
  endtask

  task automatic test_reset_mid();
    send_cmd(3'd4, 32'h99, 32'h98);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (cmd_ready !== 1'b1 || acc_ready !== 1'b0 || acc_flush !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctl: got cr=%b ar=%b fl=%b want 1/0/0", cmd_ready, acc_ready, acc_flush); end
    vectors++; if (acc_op_a !== 32'h0 || res_data !== 32'h0) begin miscompares++; $display("FAIL rstmid_regs: got %h/%h want 0/0", acc_op_a, res_data); end
    #2;
    rst_n = 1'b1;
    tick();
    #2;
    vectors++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_after: got cr=%b rv=%b want 1/0", cmd_ready, res_valid); end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    acc_pulses    = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    cmd_valid     = 1'b0;
    cmd_imm       = 3'd0;
    cmd_op_a      = 32'h0;
    cmd_op_b      = 32'h0;
    acc_res_valid = 1'b0;
    acc_res       = 32'h0;
    res_ready     = 1'b0;
    test_reset();
    test_comb();
    test_latency3();
    test_timeout();
    test_edge_result();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
